// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   IF/ID pipeline register with load-use hazard detection for the 64-bit
//   pipelined core. It captures PC/inst from instruction_fetch every cycle.
//   On a load-use hazard it holds the register, freezes the PC and bubbles
//   ID/EX. On a taken branch it flushes the fetched instruction to a NOP.
//
//   Optional feature macro: IFID_PERF_CNT_EN
//     When defined, this block keeps saturating 32-bit stall and flush counters.
//     When undefined, there are no counter registers and both outputs read 0.
//
// Ports
//   clk, reset    clock and asynchronous active-high reset
//   PC, inst      fetched PC / instruction word from instruction_fetch
//   PCSrc         taken branch this cycle; flushes IF/ID
//   IDEX_MemRead  instruction in ID/EX is a load
//   IDEX_rd       destination register of the ID/EX instruction
//   IFID_PC       registered PC
//   IFID_inst     registered instruction
//   IFID_valid    registered instruction is real (0 for bubble/flush)
//   PCnotWrite    hold the PC in instruction_fetch
//   ctrl_bubble   zero the ID/EX control signals this cycle
//   state         FSM state: 0 RUN, 1 STALL, 2 FLUSH
//   stall_count   number of stall edges taken (0 without IFID_PERF_CNT_EN)
//   flush_count   number of flush edges taken (0 without IFID_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int unsigned XLEN     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC,
    input  logic [31:0]     inst,
    input  logic            PCSrc,
    input  logic            IDEX_MemRead,
    input  logic [4:0]      IDEX_rd,
    output logic [XLEN-1:0] IFID_PC,
    output logic [31:0]     IFID_inst,
    output logic            IFID_valid,
    output logic            PCnotWrite,
    output logic            ctrl_bubble,
    output logic [1:0]      state,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic            r_valid;

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_opcode;
    logic            w_uses_rs2;
    logic            w_hazard;

    // Field decode of the instruction held in IF/ID
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_opcode = r_inst[6:0];

    // Only R, S and B formats actually read rs2; other formats reuse those
    // bits as immediate and must not raise a false stall.
    assign w_uses_rs2 = (w_opcode == 7'b0110011) ||
                        (w_opcode == 7'b0100011) ||
                        (w_opcode == 7'b1100011);

    // A flushed entry (valid=0) or a load into x0 never stalls.
    assign w_hazard = r_valid && IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IDEX_rd == w_rs1) || (w_uses_rs2 && (IDEX_rd == w_rs2)));

    // A taken branch squashes the stalled instruction, so the stall is dropped.
    assign PCnotWrite  = w_hazard && !PCSrc;
    assign ctrl_bubble = w_hazard && !PCSrc;

    assign IFID_PC    = r_pc;
    assign IFID_inst  = r_inst;
    assign IFID_valid = r_valid;
    assign state      = r_state;

    // FSM next state: flush has priority over stall from every state
    always_comb begin
        w_state_next = ST_RUN;
        if (PCSrc) begin
            w_state_next = ST_FLUSH;
        end else if (w_hazard) begin
            w_state_next = ST_STALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // IF/ID register: flush, else hold on stall, else capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (PCSrc) begin
            r_pc    <= PC;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_pc    <= PC;
            r_inst  <= inst;
            r_valid <= 1'b1;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating increment: sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (PCSrc) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (w_hazard) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
